// File: rtl/output_bcd_seq_display.sv
// Sequential 7-segment display driver: captures a result word, converts its magnitude
// to BCD with a bit-serial double-dabble, and holds sign/digit segment codes.
//
//   state  | meaning
//   IDLE   | displays held, waiting for start
//   SHIFT  | one double-dabble step per cycle, DATA_W steps
//   UPDATE | load display registers from BCD/ovf, pulse done
module output_bcd_seq_display #(
    parameter int DATA_W         = 32,
    parameter int DIGITS         = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            seg_sign,
    output logic [7*DIGITS-1:0]   seg_digits
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    logic [1:0]           state;
    logic                 negQ;
    logic [DATA_W-1:0]    magQ;
    logic [BCD_W-1:0]     bcdQ;
    logic                 ovfQ;
    logic [CNT_W-1:0]     bitCnt;
    logic                 doneQ;
    logic                 ovfOutQ;
    logic [6:0]           segSignQ;
    logic [7*DIGITS-1:0]  segDigitsQ;

    logic [BCD_W-1:0]     bcdAdj;
    logic [7*DIGITS-1:0]  segDigitsNext;
    logic [3:0]           nib;
    logic                 higherZero;

    function automatic logic [6:0] segCode(input logic [3:0] n);
        case (n)
            4'd0:    segCode = 7'h3F;
            4'd1:    segCode = 7'h06;
            4'd2:    segCode = 7'h5B;
            4'd3:    segCode = 7'h4F;
            4'd4:    segCode = 7'h66;
            4'd5:    segCode = 7'h6D;
            4'd6:    segCode = 7'h7D;
            4'd7:    segCode = 7'h07;
            4'd8:    segCode = 7'h7F;
            4'd9:    segCode = 7'h6F;
            default: segCode = 7'h00;
        endcase
    endfunction

    always_comb begin
        bcdAdj = bcdQ;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcdQ[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcdQ[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scan from the most significant digit so a zero is blanked only while every
    // digit above it is also zero; the ones digit is never blanked.
    always_comb begin
        segDigitsNext = '0;
        higherZero    = 1'b1;
        nib           = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcdQ[4*i +: 4];
            if (ovfQ) begin
                segDigitsNext[7*i +: 7] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (i != 0) && higherZero && (nib == 4'd0)) begin
                segDigitsNext[7*i +: 7] = SEG_BLANK;
            end else begin
                segDigitsNext[7*i +: 7] = segCode(nib);
            end
            if (nib != 4'd0) begin
                higherZero = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            negQ       <= 1'b0;
            magQ       <= '0;
            bcdQ       <= '0;
            ovfQ       <= 1'b0;
            bitCnt     <= '0;
            doneQ      <= 1'b0;
            ovfOutQ    <= 1'b0;
            segSignQ   <= SEG_BLANK;
            segDigitsQ <= '0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        negQ   <= signed_mode & in_data[DATA_W-1];
                        magQ   <= (signed_mode & in_data[DATA_W-1]) ? ('0 - in_data) : in_data;
                        bcdQ   <= '0;
                        ovfQ   <= 1'b0;
                        bitCnt <= CNT_LAST;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcdQ <= {bcdAdj[BCD_W-2:0], magQ[DATA_W-1]};
                    magQ <= {magQ[DATA_W-2:0], 1'b0};
                    ovfQ <= ovfQ | bcdAdj[BCD_W-1];
                    if (bitCnt == '0) begin
                        state <= UPDATE;
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
                UPDATE: begin
                    segDigitsQ <= segDigitsNext;
                    segSignQ   <= negQ ? SEG_DASH : SEG_BLANK;
                    ovfOutQ    <= ovfQ;
                    doneQ      <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = doneQ;
    assign overflow   = ovfOutQ;
    assign seg_sign   = (SEG_ACTIVE_LOW != 0) ? ~segSignQ : segSignQ;
    assign seg_digits = (SEG_ACTIVE_LOW != 0) ? ~segDigitsQ : segDigitsQ;

endmodule

// File: tb/tb_output_bcd_seq_display.sv
// Directed bench for output_bcd_seq_display: a decimal reference model fills a
// scoreboard queue at each start, entries are popped and compared on done.
module tb_output_bcd_seq_display;

    typedef struct packed {
        logic [6:0]  sign;
        logic [27:0] digits;
        logic        ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_mode;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [6:0]  seg_sign;
    logic [27:0] seg_digits;

    int   nAsserts = 0;
    int   nFail    = 0;
    exp_t sbQ[$];

    logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    output_bcd_seq_display #(
        .DATA_W(32), .DIGITS(4), .SEG_ACTIVE_LOW(0), .BLANK_LZ(1)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .signed_mode(signed_mode),
        .in_data(in_data), .busy(busy), .done(done), .overflow(overflow),
        .seg_sign(seg_sign), .seg_digits(seg_digits)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] v, input bit sm);
        exp_t              e;
        bit                neg;
        longint unsigned   mag;
        longint unsigned   p;
        neg    = sm && v[31];
        mag    = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        e.sign = neg ? 7'h40 : 7'h00;
        e.ovf  = (mag > 9999);
        e.digits = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (e.ovf)
                e.digits[7*i +: 7] = 7'h40;
            else if (i > 0 && mag < p)
                e.digits[7*i +: 7] = 7'h00;
            else
                e.digits[7*i +: 7] = segTab[int'((mag / p) % 10)];
            p = p * 10;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBlank(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_ovf"}, {31'h0, overflow}, 32'h0);
        chk({tag, "_sign"}, {25'h0, seg_sign}, 32'h0);
        chk({tag, "_digits"}, {4'h0, seg_digits}, 32'h0);
    endtask

    // injectAt > 0: a second start (with different data) is sampled at edge E<injectAt>.
    task automatic convert(input logic [31:0] v, input bit sm, input int injectAt);
        exp_t e;
        bit   got;
        int   lat;
        int   busyDrop;
        int   extraDone;
        @(negedge clock);
        in_data     = v;
        signed_mode = sm;
        start       = 1'b1;
        sbQ.push_back(model(v, sm));
        @(posedge clock);
        #1 start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        got = 0; lat = 0; busyDrop = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            if (k == injectAt) begin
                in_data     = 32'd555;
                signed_mode = 1'b0;
                start       = 1'b1;
            end
            @(posedge clock);
            #1;
            start   = 1'b0;
            in_data = ~v;
            if (done) begin
                got = 1;
                lat = k;
            end else if (!busy) begin
                busyDrop++;
            end
        end
        chk("done_seen", {31'h0, got}, 32'h1);
        chk("latency", lat, 32'd33);
        chk("busy_gap", busyDrop, 32'd0);
        e = sbQ.pop_front();
        if (got) begin
            chk("busy_at_done", {31'h0, busy}, 32'h0);
            chk("sign", {25'h0, seg_sign}, {25'h0, e.sign});
            chk("digits", {4'h0, seg_digits}, {4'h0, e.digits});
            chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
            @(posedge clock);
            #1;
            chk("done_one_cycle", {31'h0, done}, 32'h0);
            chk("digits_held", {4'h0, seg_digits}, {4'h0, e.digits});
        end
        if (injectAt > 0) begin
            extraDone = 0;
            repeat (40) begin
                @(posedge clock);
                #1;
                if (done) extraDone++;
            end
            chk("no_queued_start", extraDone, 32'd0);
            chk("digits_after_ignore", {4'h0, seg_digits}, {4'h0, e.digits});
        end
    endtask

    initial begin
        int extraDone;
        resetn      = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        in_data     = '0;
        repeat (3) @(posedge clock);
        #1 checkBlank("reset");
        @(negedge clock);
        resetn = 1'b1;

        convert(32'd123, 1'b0, 0);
        convert(32'hFFFF_FFD3, 1'b1, 0);
        convert(32'd0, 1'b0, 0);
        convert(32'd9999, 1'b0, 0);
        convert(32'd10000, 1'b0, 0);
        convert(32'h8000_0000, 1'b1, 0);
        convert(32'd42, 1'b0, 5);
        convert(32'd5, 1'b1, 0);
        convert(32'h8000_0000, 1'b0, 0);

        // Abort a conversion with reset during shift 10; display must clear at once.
        @(negedge clock);
        in_data     = 32'd1234;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #2 resetn = 1'b0;
        #1 checkBlank("abort");
        @(negedge clock);
        resetn = 1'b1;
        extraDone = 0;
        repeat (45) begin
            @(posedge clock);
            #1;
            if (done) extraDone++;
        end
        chk("no_done_after_abort", extraDone, 32'd0);
        convert(32'd7, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
